note_poly_alloc: RTL and testbench

Polyphonic voice allocator. It sits between the MIDI note_on/note_off decoder and a bank of VOICES oscillator/envelope voices, and it decides which voice plays each incoming note. It is the multi-voice counterpart of the monophonic note tracker. It shares the voice bank between notes using a scan state machine and round-robin stealing when every voice is busy.

---
 rtl/note_poly_alloc.sv | 134 +++++++++++++
 tb/tb_note_poly_alloc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_poly_alloc.sv
// Polyphonic voice allocator: scans the voice bank once per note event and
// assigns a voice by match, then free, then round-robin steal.
module note_poly_alloc #(
    parameter int VOICES     = 8,
    parameter int VOICE_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  note_on,
    input  logic                  note_off,
    input  logic [6:0]            note,
    output logic                  ready,
    output logic [VOICES*7-1:0]   voice_note,
    output logic [VOICES-1:0]     voice_gate,
    output logic [VOICES-1:0]     voice_trig,
    output logic                  steal,
    output logic                  drop
);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

    localparam logic [VOICE_BITS-1:0] IDX_ONE  = VOICE_BITS'(1);
    localparam logic [VOICE_BITS-1:0] IDX_LAST = VOICE_BITS'(VOICES - 1);

    state_t                state, state_nxt;
    logic [6:0]            notes [VOICES];
    logic [VOICES-1:0]     gates;
    logic [6:0]            ev_note;
    logic                  ev_on;
    logic [VOICE_BITS-1:0] scan_idx, steal_ptr, match_idx, free_idx, sel_idx;
    logic                  match_found, free_found;
    logic                  strobe;

    assign strobe     = note_on | note_off;
    assign ready      = (state == IDLE) && !rst;
    assign voice_gate = gates;

    always_comb begin
        voice_note = '0;
        for (int unsigned i = 0; i < VOICES; i++)
            voice_note[7*i +: 7] = notes[i];
    end

    always_comb begin
        sel_idx = steal_ptr;
        if (match_found)
            sel_idx = match_idx;
        else if (free_found)
            sel_idx = free_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (strobe) state_nxt = SCAN;
            SCAN:    if (scan_idx == IDX_LAST) state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < VOICES; i++)
                notes[i] <= '0;
            gates       <= '0;
            voice_trig  <= '0;
            steal       <= 1'b0;
            drop        <= 1'b0;
            steal_ptr   <= '0;
            scan_idx    <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            ev_note     <= '0;
            ev_on       <= 1'b0;
        end else begin
            voice_trig <= '0;
            steal      <= 1'b0;
            drop       <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe) begin
                        ev_note     <= note;
                        ev_on       <= note_on;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        drop        <= note_on & note_off;
                    end
                end
                SCAN: begin
                    drop <= strobe;
                    // First hit wins, so each search yields the lowest qualifying index.
                    if (!match_found && notes[scan_idx] == ev_note) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!free_found && !gates[scan_idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + IDX_ONE;
                end
                APPLY: begin
                    drop <= strobe;
                    if (ev_on) begin
                        notes[sel_idx]      <= ev_note;
                        gates[sel_idx]      <= 1'b1;
                        voice_trig[sel_idx] <= 1'b1;
                        if (!match_found && !free_found) begin
                            steal     <= 1'b1;
                            steal_ptr <= (steal_ptr == IDX_LAST) ? '0 : steal_ptr + IDX_ONE;
                        end
                    end else begin
                        for (int unsigned i = 0; i < VOICES; i++)
                            if (gates[i] && notes[i] == ev_note)
                                gates[i] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_note_poly_alloc.sv
// Scoreboard bench for note_poly_alloc: a queue-based voice model predicts each
// event's outcome; a monitor compares when the allocator returns to ready.
module tb_note_poly_alloc;

    localparam int V = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           note_on = 1'b0;
    logic           note_off = 1'b0;
    logic [6:0]     note = '0;
    logic           ready;
    logic [V*7-1:0] voice_note;
    logic [V-1:0]   voice_gate;
    logic [V-1:0]   voice_trig;
    logic           steal;
    logic           drop;

    note_poly_alloc #(.VOICES(V), .VOICE_BITS(3)) dut (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off), .note(note),
        .ready(ready), .voice_note(voice_note), .voice_gate(voice_gate),
        .voice_trig(voice_trig), .steal(steal), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [V*7-1:0] notes;
        logic [V-1:0]   gates;
        logic [V-1:0]   trig;
        logic           stl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_drops = 0;
    int   drops_seen = 0;
    int   m_note [V];
    bit   m_gate [V];
    int   m_sp = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < V; i++) begin
            m_note[i] = 0;
            m_gate[i] = 0;
        end
        m_sp = 0;
    endfunction

    // Reference behaviour: match, else free, else steal at the round-robin pointer.
    function automatic exp_t model_event(bit on, int n);
        exp_t e;
        int   pick;
        e.trig = '0;
        e.stl  = 1'b0;
        if (on) begin
            pick = -1;
            for (int i = 0; i < V && pick < 0; i++)
                if (m_note[i] == n) pick = i;
            for (int i = 0; i < V && pick < 0; i++)
                if (!m_gate[i]) pick = i;
            if (pick < 0) begin
                pick  = m_sp;
                e.stl = 1'b1;
                m_sp  = (m_sp + 1) % V;
            end
            m_note[pick] = n;
            m_gate[pick] = 1;
            e.trig[pick] = 1'b1;
        end else begin
            for (int i = 0; i < V; i++)
                if (m_note[i] == n && m_gate[i]) m_gate[i] = 0;
        end
        for (int i = 0; i < V; i++) begin
            e.notes[7*i +: 7] = 7'(m_note[i]);
            e.gates[i]        = m_gate[i];
        end
        return e;
    endfunction

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=0 expected=1 t=%0t", $time);
        end
    endtask

    task automatic accept(input bit on, input bit off, input int n);
        wait_ready();
        note_on  = on;
        note_off = off;
        note     = 7'(n);
        @(posedge clk);
        #1;
        note_on  = 1'b0;
        note_off = 1'b0;
        if (on && off) exp_drops++;
        exp_q.push_back(model_event(on, n));
    endtask

    task automatic strobe_busy(input int n);
        repeat ($urandom_range(1, V)) @(negedge clk);
        if (!ready) begin
            note_on = 1'b1;
            note    = 7'(n);
            @(posedge clk);
            #1;
            note_on = 1'b0;
            exp_drops++;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_note", 64'(voice_note), 64'd0);
        check("rst_gate", 64'(voice_gate), 64'd0);
        check("rst_trig_steal_drop", {61'd0, |voice_trig, steal, drop}, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    bit busy = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy = 0;
        end else begin
            exp_t e;
            if (drop) drops_seen++;
            check("trig_onehot", 64'($countones(voice_trig) <= 1), 64'd1);
            if (!ready) busy = 1;
            if (ready && busy) begin
                busy = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL apply_unexpected got=1 expected=0 t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("apply_note", 64'(voice_note), 64'(e.notes));
                    check("apply_gate", 64'(voice_gate), 64'(e.gates));
                    check("apply_trig", 64'(voice_trig), 64'(e.trig));
                    check("apply_steal", 64'(steal), 64'(e.stl));
                end
            end else begin
                check("idle_pulse", {55'd0, voice_trig, steal}, 64'd0);
            end
        end
    end

    initial begin
        int k;
        model_reset();
        do_reset();

        // First event: trig appears V+1 edges after acceptance.
        accept(1, 0, 60);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (voice_trig == '0 && k < 40);
        check("latency", 64'(k), 64'(V + 2));
        accept(1, 0, 62);
        accept(1, 0, 64);
        accept(0, 1, 62);
        wait_ready();
        check("gate_after_off", 64'(voice_gate), 64'b101);

        wait_ready();
        do_reset();
        for (int n = 40; n < 48; n++) accept(1, 0, n);
        accept(1, 0, 50);
        accept(1, 0, 51);
        accept(1, 0, 50);
        accept(0, 1, 50);
        accept(1, 0, 50);
        accept(0, 1, 99);
        accept(1, 1, 72);
        accept(1, 0, 44);
        strobe_busy(70);
        wait_ready();

        accept(1, 0, 80);
        repeat (3) @(negedge clk);
        do_reset();
        accept(1, 0, 81);
        wait_ready();
        check("after_rst_v0", 64'(voice_note[6:0]), 64'd81);

        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 99);
            int n = 40 + $urandom_range(0, 11);
            if (r < 65)      accept(1, 0, n);
            else if (r < 93) accept(0, 1, n);
            else             accept(1, 1, n);
            if ($urandom_range(0, 9) < 3) strobe_busy(n);
        end

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("drop_count", 64'(drops_seen), 64'(exp_drops));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
